// File: rtl/mult_limb_pkg.sv
// Shared types and size helpers for the limb multiply-accumulate engine.
package mult_limb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_LIMB     = 16;
  localparam int unsigned DEF_A_BITS   = 130;
  localparam int unsigned DEF_B_BITS   = 128;
  localparam int unsigned DEF_PPC      = 4;
  localparam int unsigned DEF_TAG_BITS = 4;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

  function automatic int unsigned limb_count(input int unsigned bits, input int unsigned limb);
    return ceil_div(bits, limb);
  endfunction

  function automatic int unsigned total_partials(input int unsigned a_bits, input int unsigned b_bits,
                                                 input int unsigned limb);
    return limb_count(a_bits, limb) * limb_count(b_bits, limb);
  endfunction

  function automatic int unsigned calc_cycles(input int unsigned total, input int unsigned ppc);
    return ceil_div(total, ppc);
  endfunction

  function automatic int unsigned prod_bits(input int unsigned a_bits, input int unsigned b_bits);
    return a_bits + b_bits + 1;
  endfunction

endpackage

// File: rtl/mult_limb_mac_seq_pp.sv
// One limb partial product, zero-extended and placed at its limb offset.
module mult_limb_pp #(
  parameter int unsigned LIMB      = 16,
  parameter int unsigned OFF_W     = 5,
  parameter int unsigned PROD_BITS = 259
) (
  input  logic                 i_valid,
  input  logic [LIMB-1:0]      i_a_limb,
  input  logic [LIMB-1:0]      i_b_limb,
  input  logic [OFF_W-1:0]     i_offset,
  output logic [PROD_BITS-1:0] o_pp
);

  logic [2*LIMB-1:0] w_raw;

  always_comb begin
    w_raw = {{LIMB{1'b0}}, i_a_limb} * {{LIMB{1'b0}}, i_b_limb};
    // Limb products never exceed the true a*b span, so narrowing to PROD_BITS drops only zeros.
    o_pp  = i_valid ? (PROD_BITS'(w_raw) << (32'(i_offset) * LIMB)) : '0;
  end

endmodule

// File: rtl/mult_limb_mac_seq.sv
// Sequential limb-based a*b / a*b+c engine with valid/ready handshakes, tag and flush.
module mult_limb_mac_seq
  import mult_limb_pkg::*;
#(
  parameter int unsigned LIMB               = DEF_LIMB,
  parameter int unsigned A_BITS             = DEF_A_BITS,
  parameter int unsigned B_BITS             = DEF_B_BITS,
  parameter int unsigned PARTIALS_PER_CYCLE = DEF_PPC,
  parameter int unsigned TAG_BITS           = DEF_TAG_BITS
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic [A_BITS-1:0]          in_a,
  input  logic [B_BITS-1:0]          in_b,
  input  logic [A_BITS+B_BITS-1:0]   in_c,
  input  logic [TAG_BITS-1:0]        in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_BITS+B_BITS:0]     out_product,
  output logic [TAG_BITS-1:0]        out_tag,
  output logic                       busy
);

  localparam int unsigned A_LIMBS   = limb_count(A_BITS, LIMB);
  localparam int unsigned B_LIMBS   = limb_count(B_BITS, LIMB);
  localparam int unsigned TOTAL     = total_partials(A_BITS, B_BITS, LIMB);
  localparam int unsigned PROD_BITS = prod_bits(A_BITS, B_BITS);
  localparam int unsigned A_PAD     = A_LIMBS * LIMB;
  localparam int unsigned B_PAD     = B_LIMBS * LIMB;
  localparam int unsigned OFF_W     = $clog2(A_LIMBS + B_LIMBS);
  localparam int unsigned IDX_W     = $clog2(TOTAL + PARTIALS_PER_CYCLE + 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [A_PAD-1:0]       r_a;
  logic [B_PAD-1:0]       r_b;
  logic [TAG_BITS-1:0]    r_tag;
  logic [PROD_BITS-1:0]   r_acc;
  logic [IDX_W-1:0]       r_idx;
  logic [PROD_BITS-1:0]   r_out_product;
  logic [TAG_BITS-1:0]    r_out_tag;
  logic                   r_out_valid;
  logic                   w_last;
  logic [PROD_BITS-1:0]   w_sum;
  logic [PROD_BITS-1:0]   w_pp [PARTIALS_PER_CYCLE];

  assign w_last = (32'(r_idx) + PARTIALS_PER_CYCLE) >= TOTAL;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid)  w_state_nxt = ST_CALC;
        ST_CALC: if (w_last)    w_state_nxt = ST_DONE;
        ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
        default:                w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (r_state == ST_IDLE);
    busy     = (r_state == ST_CALC) || (r_state == ST_DONE);
  end

  // Partial products for row-major indices r_idx .. r_idx+P-1; those past TOTAL are masked.
  for (genvar k = 0; k < PARTIALS_PER_CYCLE; k++) begin : g_pp
    logic [31:0]     w_lin;
    logic [31:0]     w_ai;
    logic [31:0]     w_bj;
    logic            w_vld;
    logic [LIMB-1:0] w_al;
    logic [LIMB-1:0] w_bl;

    assign w_lin = 32'(r_idx) + 32'(k);
    assign w_vld = w_lin < TOTAL;
    assign w_ai  = w_lin / B_LIMBS;
    assign w_bj  = w_lin % B_LIMBS;
    assign w_al  = LIMB'(r_a >> (w_ai * LIMB));
    assign w_bl  = LIMB'(r_b >> (w_bj * LIMB));

    mult_limb_pp #(
      .LIMB      (LIMB),
      .OFF_W     (OFF_W),
      .PROD_BITS (PROD_BITS)
    ) u_pp (
      .i_valid  (w_vld),
      .i_a_limb (w_al),
      .i_b_limb (w_bl),
      .i_offset (OFF_W'(w_ai + w_bj)),
      .o_pp     (w_pp[k])
    );
  end

  always_comb begin
    w_sum = r_acc;
    for (int unsigned k = 0; k < PARTIALS_PER_CYCLE; k++) begin
      w_sum = w_sum + w_pp[k];
    end
  end

  // Datapath; flush only drops out_valid and leaves the last result/tag visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a           <= '0;
      r_b           <= '0;
      r_tag         <= '0;
      r_acc         <= '0;
      r_idx         <= '0;
      r_out_product <= '0;
      r_out_tag     <= '0;
      r_out_valid   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a   <= A_PAD'(in_a);
            r_b   <= B_PAD'(in_b);
            r_tag <= in_tag;
            r_acc <= in_mode ? PROD_BITS'(in_c) : '0;
            r_idx <= '0;
          end
        end
        ST_CALC: begin
          r_acc <= w_sum;
          r_idx <= r_idx + IDX_W'(PARTIALS_PER_CYCLE);
          if (w_last) begin
            r_out_product <= w_sum;
            r_out_tag     <= r_tag;
            r_out_valid   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;
  assign out_tag     = r_out_tag;

endmodule

// File: tb/tb_mult_limb_mac_seq.sv
// Directed + random bench for mult_limb_mac_seq across several partials-per-cycle settings.
module tb_mult_limb_mac_seq;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_mode = 1'b0;
  logic [129:0] in_a = '0;
  logic [127:0] in_b = '0;
  logic [257:0] in_c = '0;
  logic [3:0]   in_tag = '0;
  logic         out_ready = 1'b1;

  logic [3:0]   in_valid_v = '0;
  logic [3:0]   in_ready_v;
  logic [3:0]   out_valid_v;
  logic [3:0]   busy_v;
  logic [258:0] out_product_v [4];
  logic [3:0]   out_tag_v [4];

  logic         l_valid = 1'b0;
  logic         l_ready;
  logic         l_mode = 1'b0;
  logic [63:0]  l_a = '0;
  logic [63:0]  l_b = '0;
  logic [127:0] l_c = '0;
  logic [3:0]   l_tag = '0;
  logic         l_ovalid;
  logic         l_oready = 1'b1;
  logic [128:0] l_prod;
  logic [3:0]   l_otag;
  logic         l_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instances 0..3 use P = 4, 1, 5, 72 on the 130x128 default geometry.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    mult_limb_mac_seq #(
      .LIMB               (16),
      .A_BITS             (130),
      .B_BITS             (128),
      .PARTIALS_PER_CYCLE (g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 5 : 72),
      .TAG_BITS           (4)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush       (flush),
      .in_valid    (in_valid_v[g]),
      .in_ready    (in_ready_v[g]),
      .in_mode     (in_mode),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_c        (in_c),
      .in_tag      (in_tag),
      .out_valid   (out_valid_v[g]),
      .out_ready   (out_ready),
      .out_product (out_product_v[g]),
      .out_tag     (out_tag_v[g]),
      .busy        (busy_v[g])
    );
  end

  mult_limb_mac_seq #(
    .LIMB               (32),
    .A_BITS             (64),
    .B_BITS             (64),
    .PARTIALS_PER_CYCLE (3),
    .TAG_BITS           (4)
  ) u_dut_l32 (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (l_valid),
    .in_ready    (l_ready),
    .in_mode     (l_mode),
    .in_a        (l_a),
    .in_b        (l_b),
    .in_c        (l_c),
    .in_tag      (l_tag),
    .out_valid   (l_ovalid),
    .out_ready   (l_oready),
    .out_product (l_prod),
    .out_tag     (l_otag),
    .busy        (l_busy)
  );

  task automatic chk(input string tag, input logic [258:0] obs, input logic [258:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [257:0] rbits();
    logic [257:0] r;
    for (int i = 0; i < 258; i++) r[i] = 1'($urandom);
    return r;
  endfunction

  function automatic logic [258:0] ref_mac(input logic m, input logic [129:0] a,
                                           input logic [127:0] b, input logic [257:0] c);
    logic [258:0] p;
    p = 259'(a) * 259'(b);
    if (m) p = p + 259'(c);
    return p;
  endfunction

  task automatic start_op(input logic [1:0] sel, input logic m, input logic [129:0] a,
                          input logic [127:0] b, input logic [257:0] c, input logic [3:0] t);
    int w = 0;
    while (in_ready_v[sel] !== 1'b1 && w < 300) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_before_accept", 259'(in_ready_v[sel]), 259'(1));
    in_mode = m; in_a = a; in_b = b; in_c = c; in_tag = t;
    in_valid_v[sel] = 1'b1;
    @(posedge clk); #1;
    in_valid_v = '0;
    in_a = 130'(rbits()); in_b = 128'(rbits()); in_c = rbits(); in_mode = ~m;
  endtask

  task automatic wait_valid(input logic [1:0] sel, output int cyc);
    cyc = 0;
    while (out_valid_v[sel] !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic run_op(input logic [1:0] sel, input logic m, input logic [129:0] a,
                        input logic [127:0] b, input logic [257:0] c, input logic [3:0] t,
                        input int exp_n, input logic [258:0] e, input string name);
    int cyc;
    start_op(sel, m, a, b, c, t);
    wait_valid(sel, cyc);
    chk({name, "_latency"}, 259'(cyc), 259'(exp_n));
    chk({name, "_product"}, out_product_v[sel], e);
    chk({name, "_tag"}, 259'(out_tag_v[sel]), 259'(t));
    @(posedge clk); #1;
    chk({name, "_back_idle"}, 259'(in_ready_v[sel]), 259'(1));
    chk({name, "_valid_drop"}, 259'(out_valid_v[sel]), 259'(0));
  endtask

  task automatic run_l32(input logic m, input logic [63:0] a, input logic [63:0] b,
                         input logic [127:0] c, input logic [3:0] t);
    logic [128:0] e;
    int cyc = 0;
    e = 129'(a) * 129'(b);
    if (m) e = e + 129'(c);
    l_mode = m; l_a = a; l_b = b; l_c = c; l_tag = t; l_valid = 1'b1;
    @(posedge clk); #1;
    l_valid = 1'b0; l_a = ~a; l_b = ~b;
    while (l_ovalid !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("l32_latency", 259'(cyc), 259'(2));
    chk("l32_product", 259'(l_prod), 259'(e));
    chk("l32_tag", 259'(l_otag), 259'(t));
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [129:0] amax;
    logic [127:0] bmax;
    logic [257:0] cmax;
    logic [259:0] wide;
    logic [129:0] ra;
    logic [127:0] rb;
    logic [257:0] rc;
    logic [258:0] e;
    logic [258:0] last_prod;
    int           cyc;
    int           seen;
    int           nexp [4];

    amax = '1; bmax = '1; cmax = '1;
    nexp[0] = 18; nexp[1] = 72; nexp[2] = 15; nexp[3] = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 259'(in_ready_v[0]), 259'(1));
    chk("rst_out_valid", 259'(out_valid_v[0]), 259'(0));
    chk("rst_busy", 259'(busy_v[0]), 259'(0));
    chk("rst_product", out_product_v[0], 259'(0));
    chk("rst_tag", 259'(out_tag_v[0]), 259'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 259'(in_ready_v[0]), 259'(1));
    chk("post_rst_busy", 259'(busy_v[0]), 259'(0));

    wide = (260'(1) << 258) - (260'(1) << 130) - (260'(1) << 128) + 260'(1);
    run_op(2'd0, 1'b0, amax, bmax, cmax, 4'h3, 18, 259'(wide), "mul_max");
    run_op(2'd0, 1'b1, 130'd3, 128'd5, 258'd7, 4'h5, 18, 259'd22, "mac_small");
    wide = (260'(1) << 259) - (260'(1) << 130) - (260'(1) << 128);
    run_op(2'd0, 1'b1, amax, bmax, cmax, 4'hA, 18, 259'(wide), "mac_max");
    ra = 130'(rbits()); rb = 128'(rbits()); rc = rbits();
    run_op(2'd0, 1'b0, ra, rb, rc, 4'h1, 18, ref_mac(1'b0, ra, rb, rc), "mul_rand_c_ignored");

    // Output backpressure with ignored input pulses.
    out_ready = 1'b0;
    ra = 130'(rbits()); rb = 128'(rbits()); rc = rbits();
    e = ref_mac(1'b1, ra, rb, rc);
    start_op(2'd0, 1'b1, ra, rb, rc, 4'h9);
    wait_valid(2'd0, cyc);
    chk("bp_latency", 259'(cyc), 259'(18));
    for (int i = 0; i < 10; i++) begin
      in_valid_v[0] = i[0];
      in_a = 130'(rbits()); in_tag = 4'(i);
      @(posedge clk); #1;
      chk("bp_product", out_product_v[0], e);
      chk("bp_tag", 259'(out_tag_v[0]), 259'(4'h9));
      chk("bp_in_ready", 259'(in_ready_v[0]), 259'(0));
      chk("bp_valid", 259'(out_valid_v[0]), 259'(1));
    end
    in_valid_v = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 259'(out_valid_v[0]), 259'(0));
    chk("bp_release_ready", 259'(in_ready_v[0]), 259'(1));
    chk("bp_release_busy", 259'(busy_v[0]), 259'(0));
    last_prod = e;

    // Flush on the 9th CALC cycle.
    start_op(2'd0, 1'b0, amax, bmax, '0, 4'h7);
    repeat (8) @(posedge clk);
    #1;
    chk("pre_flush_busy", 259'(busy_v[0]), 259'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", 259'(in_ready_v[0]), 259'(1));
    chk("flush_busy", 259'(busy_v[0]), 259'(0));
    chk("flush_valid", 259'(out_valid_v[0]), 259'(0));
    chk("flush_product_kept", out_product_v[0], last_prod);
    chk("flush_tag_kept", 259'(out_tag_v[0]), 259'(4'h9));
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid_v[0] === 1'b1) seen++;
    end
    chk("flush_no_result", 259'(seen), 259'(0));
    in_valid_v[0] = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid_v = '0; flush = 1'b0;
    chk("flush_drops_accept", 259'(busy_v[0]), 259'(0));
    run_op(2'd0, 1'b0, 130'h1234, 128'hFFFF, '0, 4'h2, 18, 259'h1233EDCC, "mul_after_flush");

    // Sweep of partials-per-cycle with random operands.
    for (int s = 1; s < 4; s++) begin
      for (int k = 0; k < 2; k++) begin
        ra = 130'(rbits()); rb = 128'(rbits()); rc = rbits();
        run_op(2'(s), k[0], ra, rb, rc, 4'($urandom), nexp[s], ref_mac(k[0], ra, rb, rc), "sweep");
      end
    end

    for (int k = 0; k < 3; k++) begin
      run_l32(k[0], {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 4'(k + 3));
    end
    run_l32(1'b1, '1, '1, '1, 4'hF);

    // Asynchronous reset in the middle of CALC.
    start_op(2'd0, 1'b1, amax, bmax, cmax, 4'hC);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    chk("arst_in_ready", 259'(in_ready_v[0]), 259'(1));
    chk("arst_out_valid", 259'(out_valid_v[0]), 259'(0));
    chk("arst_busy", 259'(busy_v[0]), 259'(0));
    chk("arst_product", out_product_v[0], 259'(0));
    chk("arst_tag", 259'(out_tag_v[0]), 259'(0));
    chk("arst_l32_product", 259'(l_prod), 259'(0));
    #4;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid_v[0] === 1'b1) seen++;
    end
    chk("arst_no_result", 259'(seen), 259'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
